lsu_mem_master: RTL and testbench

- Load/store initiator that drives the word-organised data memory port on behalf of the core's execute stage.
- Turns RV32I byte, halfword and word loads/stores into word-aligned memory transactions.
- Sub-word loads use sign or zero extension. Sub-word stores use read-modify-write.
- Sits between the execute stage (valid/ready request, single-cycle response pulse) and the data memory (combinational read, write on the clock edge).

---
 rtl/lsu_mem_master.sv | 218 +++++++++++++++++++++
 tb/tb_lsu_mem_master.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_master.sv
// ---------------------------------------------------------------------------
// lsu_mem_master
// Load/store initiator between the execute stage and a word-organised data
// memory. RV32I byte/halfword/word accesses become word-aligned memory
// transactions. Sub-word loads are sign/zero extended and sub-word stores
// use read-modify-write.
//
// Ports
//   clk, rst            clock (rising edge), asynchronous active-low reset
//   req_*               execute-stage request (valid/ready handshake)
//   resp_*              one-cycle response pulse with load data and error
//   byte_address        word-aligned memory address
//   write_data          merged store word
//   MemRead, MemWrite   memory strobes
//   output_data         memory read word (combinational with the address)
//
// state | meaning
// IDLE  | ready for a request; classifies it at the accept edge
// RD    | memory read strobe; load data or RMW source captured
// WR    | memory write strobe with the merged word
// RESP  | one-cycle response pulse
// ---------------------------------------------------------------------------
module lsu_mem_master #(
   parameter int unsigned ADDR_BITS = 10
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic [31:0] byte_address,
   output logic [31:0] write_data,
   output logic        MemWrite,
   output logic        MemRead,
   input  logic [31:0] output_data
);

   typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

   state_t      state_q, state_d;
   logic        write_q, write_d;
   logic [2:0]  funct3_q, funct3_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] wmem_q, wmem_d;
   logic [31:0] rdata_q, rdata_d;
   logic        err_q, err_d;
   logic        ready_q, ready_d;
   logic        mem_rd_q, mem_rd_d;
   logic        mem_wr_q, mem_wr_d;
   logic        rvalid_q, rvalid_d;
   logic        rerr_q, rerr_d;

   logic        req_err;

   function automatic logic [31:0] load_extend(input logic [31:0] word,
                                               input logic [2:0]  f3,
                                               input logic [1:0]  a);
      logic [31:0] b_sh;
      logic [31:0] h_sh;
      logic [31:0] res;
      b_sh = word >> {a, 3'b000};
      h_sh = word >> {a[1], 4'b0000};
      case (f3)
         3'b000:  res = {{24{b_sh[7]}}, b_sh[7:0]};
         3'b100:  res = {24'd0, b_sh[7:0]};
         3'b001:  res = {{16{h_sh[15]}}, h_sh[15:0]};
         3'b101:  res = {16'd0, h_sh[15:0]};
         default: res = word;
      endcase
      return res;
   endfunction

   function automatic logic [31:0] store_merge(input logic [31:0] word,
                                               input logic [31:0] data,
                                               input logic [2:0]  f3,
                                               input logic [1:0]  a);
      logic [31:0] mask;
      logic [31:0] ins;
      if (f3 == 3'b000) begin
         mask = 32'h0000_00ff << {a, 3'b000};
         ins  = {24'd0, data[7:0]} << {a, 3'b000};
      end else begin
         mask = 32'h0000_ffff << {a[1], 4'b0000};
         ins  = {16'd0, data[15:0]} << {a[1], 4'b0000};
      end
      return (word & ~mask) | (ins & mask);
   endfunction

   // Error classification of the request presented in IDLE.
   always_comb begin
      req_err = 1'b0;
      if (req_write) begin
         if (req_funct3 != 3'b000 && req_funct3 != 3'b001 && req_funct3 != 3'b010)
            req_err = 1'b1;
      end else begin
         if (req_funct3 == 3'b011 || req_funct3[2:1] == 2'b11)
            req_err = 1'b1;
      end
      if (req_funct3[1:0] == 2'b01 && req_addr[0])
         req_err = 1'b1;
      if (req_funct3 == 3'b010 && req_addr[1:0] != 2'b00)
         req_err = 1'b1;
      if ((req_addr >> ADDR_BITS) != 32'd0)
         req_err = 1'b1;
   end

   always_comb begin
      state_d  = state_q;
      write_d  = write_q;
      funct3_d = funct3_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      wmem_d   = wmem_q;
      rdata_d  = rdata_q;
      err_d    = err_q;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               write_d  = req_write;
               funct3_d = req_funct3;
               addr_d   = req_addr;
               wdata_d  = req_wdata;
               err_d    = req_err;
               if (req_err) begin
                  state_d = RESP;
               end else if (!req_write) begin
                  state_d = RD;
               end else if (req_funct3 == 3'b010) begin
                  state_d = WR;
                  wmem_d  = req_wdata;
               end else begin
                  state_d = RD;
               end
            end
         end
         RD: begin
            // Merge is built straight from the memory word so the write
            // strobe in WR already carries the final data.
            if (write_q) begin
               state_d = WR;
               rdata_d = output_data;
               wmem_d  = store_merge(output_data, wdata_q, funct3_q, addr_q[1:0]);
            end else begin
               state_d = RESP;
               rdata_d = load_extend(output_data, funct3_q, addr_q[1:0]);
            end
         end
         WR: begin
            state_d = RESP;
            rdata_d = 32'd0;
         end
         RESP: begin
            state_d = IDLE;
            err_d   = 1'b0;
            rdata_d = 32'd0;
         end
         default: state_d = IDLE;
      endcase

      // Outputs are registered off the next state.
      ready_d  = (state_d == IDLE);
      mem_rd_d = (state_d == RD);
      mem_wr_d = (state_d == WR);
      rvalid_d = (state_d == RESP);
      rerr_d   = (state_d == RESP) && err_d;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= IDLE;
         write_q  <= 1'b0;
         funct3_q <= 3'd0;
         addr_q   <= 32'd0;
         wdata_q  <= 32'd0;
         wmem_q   <= 32'd0;
         rdata_q  <= 32'd0;
         err_q    <= 1'b0;
         ready_q  <= 1'b1;
         mem_rd_q <= 1'b0;
         mem_wr_q <= 1'b0;
         rvalid_q <= 1'b0;
         rerr_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         write_q  <= write_d;
         funct3_q <= funct3_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         wmem_q   <= wmem_d;
         rdata_q  <= rdata_d;
         err_q    <= err_d;
         ready_q  <= ready_d;
         mem_rd_q <= mem_rd_d;
         mem_wr_q <= mem_wr_d;
         rvalid_q <= rvalid_d;
         rerr_q   <= rerr_d;
      end
   end

   // rdata_q holds the RMW source word while in WR and is zeroed there, so
   // only a load response ever exposes it.
   assign req_ready    = ready_q;
   assign MemRead      = mem_rd_q;
   assign MemWrite     = mem_wr_q;
   assign resp_valid   = rvalid_q;
   assign resp_err     = rerr_q;
   assign resp_rdata   = rvalid_q ? rdata_q : 32'd0;
   assign byte_address = {addr_q[31:2], 2'b00};
   assign write_data   = wmem_q;

endmodule

// File: tb/tb_lsu_mem_master.sv
module tb_lsu_mem_master;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic [31:0] byte_address;
   logic [31:0] write_data;
   logic        MemWrite;
   logic        MemRead;
   logic [31:0] output_data;

   always #5 clk = ~clk;

   lsu_mem_master #(.ADDR_BITS(10)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
      .byte_address(byte_address), .write_data(write_data),
      .MemWrite(MemWrite), .MemRead(MemRead), .output_data(output_data)
   );

   // Memory model: 1 KB, combinational read, write on the clock edge.
   logic [31:0] mem [0:255];
   logic        pre_we = 1'b0;
   logic [7:0]  pre_idx = 8'd0;
   logic [31:0] pre_val = 32'd0;

   assign output_data = mem[byte_address[9:2]];

   always @(posedge clk) begin
      if (MemWrite)    mem[byte_address[9:2]] <= write_data;
      else if (pre_we) mem[pre_idx] <= pre_val;
   end

   int n_vec = 0;
   int n_bad = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic preload(input logic [31:0] baddr, input logic [31:0] val);
      @(negedge clk);
      pre_we  = 1'b1;
      pre_idx = baddr[9:2];
      pre_val = val;
      @(negedge clk);
      pre_we  = 1'b0;
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] baddr);
      logic [7:0] i;
      i = baddr[9:2];
      return mem[i];
   endfunction

   // One request; reports response cycle and first strobe cycles (0 = never).
   task automatic run_req(input string nm, input logic wr, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wd,
                          output int lat, output int rd_cyc, output int wr_cyc,
                          output logic [31:0] rdata, output logic err);
      lat = 0; rd_cyc = 0; wr_cyc = 0; rdata = 32'hx; err = 1'bx;
      @(negedge clk);
      chk({nm, " ready_idle"}, {31'd0, req_ready}, 32'd1);
      req_valid  = 1'b1;
      req_write  = wr;
      req_funct3 = f3;
      req_addr   = addr;
      req_wdata  = wd;
      @(posedge clk);
      #1 req_valid = 1'b0;
      for (int c = 1; c <= 8 && lat == 0; c++) begin
         @(negedge clk);
         chk({nm, " ready_busy"}, {31'd0, req_ready}, 32'd0);
         if (MemRead && rd_cyc == 0) rd_cyc = c;
         if (MemWrite && wr_cyc == 0) wr_cyc = c;
         if (MemRead || MemWrite)
            chk({nm, " byte_address"}, byte_address, {addr[31:2], 2'b00});
         if (resp_valid) begin
            lat   = c;
            rdata = resp_rdata;
            err   = resp_err;
         end else begin
            chk({nm, " err_idle"}, {31'd0, resp_err}, 32'd0);
         end
      end
      if (lat == 0) begin
         n_bad++;
         $display("FAIL %s timeout: no resp_valid within 8 cycles", nm);
      end
   endtask

   typedef struct {
      string       name;
      logic        wr;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      logic        exp_err;
      int          exp_lat;
      int          exp_rd;
      int          exp_wr;
      logic [31:0] chk_addr;
      logic [31:0] chk_word;
   } vec_t;

   typedef struct {
      logic        wr;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      logic        exp_err;
   } hs_t;

   vec_t vq[$];
   hs_t  hs[5];

   initial begin
      int          lat, rdc, wrc, acc, got;
      logic [31:0] rd;
      logic        er, was_ready, just_acc;

      // name, wr, f3, addr, wdata, rdata, err, lat, rd, wr, chk_addr, chk_word
      vq.push_back('{"lb_13",  1'b0, 3'b000, 32'h13,  32'h0,        32'hFFFFFF88, 1'b0, 2, 1, 0, 32'h10, 32'h8899AABB});
      vq.push_back('{"lbu_13", 1'b0, 3'b100, 32'h13,  32'h0,        32'h00000088, 1'b0, 2, 1, 0, 32'h10, 32'h8899AABB});
      vq.push_back('{"lh_12",  1'b0, 3'b001, 32'h12,  32'h0,        32'hFFFF8899, 1'b0, 2, 1, 0, 32'h10, 32'h8899AABB});
      vq.push_back('{"lhu_10", 1'b0, 3'b101, 32'h10,  32'h0,        32'h0000AABB, 1'b0, 2, 1, 0, 32'h10, 32'h8899AABB});
      vq.push_back('{"lw_10",  1'b0, 3'b010, 32'h10,  32'h0,        32'h8899AABB, 1'b0, 2, 1, 0, 32'h10, 32'h8899AABB});
      vq.push_back('{"sb_21",  1'b1, 3'b000, 32'h21,  32'hFFFFFFA5, 32'h0,        1'b0, 3, 1, 2, 32'h20, 32'h1122A544});
      vq.push_back('{"sh_22",  1'b1, 3'b001, 32'h22,  32'h0000BEEF, 32'h0,        1'b0, 3, 1, 2, 32'h20, 32'hBEEFA544});
      vq.push_back('{"lb_20",  1'b0, 3'b000, 32'h20,  32'h0,        32'h00000044, 1'b0, 2, 1, 0, 32'h20, 32'hBEEFA544});
      vq.push_back('{"lh_22",  1'b0, 3'b001, 32'h22,  32'h0,        32'hFFFFBEEF, 1'b0, 2, 1, 0, 32'h20, 32'hBEEFA544});
      vq.push_back('{"sw_30",  1'b1, 3'b010, 32'h30,  32'hDEADBEEF, 32'h0,        1'b0, 2, 0, 1, 32'h30, 32'hDEADBEEF});
      vq.push_back('{"lw_32",  1'b0, 3'b010, 32'h32,  32'h0,        32'h0,        1'b1, 1, 0, 0, 32'h30, 32'hDEADBEEF});
      vq.push_back('{"sh_31",  1'b1, 3'b001, 32'h31,  32'h1234,     32'h0,        1'b1, 1, 0, 0, 32'h30, 32'hDEADBEEF});
      vq.push_back('{"lb_f3_3",1'b0, 3'b011, 32'h10,  32'h0,        32'h0,        1'b1, 1, 0, 0, 32'h10, 32'h8899AABB});
      vq.push_back('{"sb_400", 1'b1, 3'b000, 32'h400, 32'h77,       32'h0,        1'b1, 1, 0, 0, 32'h0,  32'h55AA55AA});
      vq.push_back('{"s_f3_4", 1'b1, 3'b100, 32'h20,  32'h77,       32'h0,        1'b1, 1, 0, 0, 32'h20, 32'hBEEFA544});

      hs[0] = '{1'b0, 3'b010, 32'h10, 32'h0,  32'h8899AABB, 1'b0};
      hs[1] = '{1'b1, 3'b000, 32'h50, 32'h77, 32'h0,        1'b0};
      hs[2] = '{1'b0, 3'b100, 32'h50, 32'h0,  32'h00000077, 1'b0};
      hs[3] = '{1'b0, 3'b010, 32'h33, 32'h0,  32'h0,        1'b1};
      hs[4] = '{1'b0, 3'b101, 32'h52, 32'h0,  32'h00000102, 1'b0};

      rst = 1'b0;
      req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'd0;
      req_addr = 32'd0; req_wdata = 32'd0;

      preload(32'h00, 32'h55AA55AA);
      preload(32'h10, 32'h8899AABB);
      preload(32'h20, 32'h11223344);
      preload(32'h30, 32'h00000000);
      preload(32'h40, 32'hCAFEF00D);
      preload(32'h50, 32'h01020304);

      // Reset values.
      @(negedge clk);
      n_vec++;
      chk("rst req_ready", {31'd0, req_ready}, 32'd1);
      chk("rst resp_valid", {31'd0, resp_valid}, 32'd0);
      chk("rst resp_err", {31'd0, resp_err}, 32'd0);
      chk("rst resp_rdata", resp_rdata, 32'd0);
      chk("rst MemRead", {31'd0, MemRead}, 32'd0);
      chk("rst MemWrite", {31'd0, MemWrite}, 32'd0);
      chk("rst byte_address", byte_address, 32'd0);
      chk("rst write_data", write_data, 32'd0);
      rst = 1'b1;

      // Table-driven directed vectors.
      foreach (vq[i]) begin
         n_vec++;
         run_req(vq[i].name, vq[i].wr, vq[i].f3, vq[i].addr, vq[i].wdata,
                 lat, rdc, wrc, rd, er);
         chk({vq[i].name, " latency"}, lat, vq[i].exp_lat);
         chk({vq[i].name, " rd_cycle"}, rdc, vq[i].exp_rd);
         chk({vq[i].name, " wr_cycle"}, wrc, vq[i].exp_wr);
         chk({vq[i].name, " rdata"}, rd, vq[i].exp_rdata);
         chk({vq[i].name, " err"}, {31'd0, er}, {31'd0, vq[i].exp_err});
         chk({vq[i].name, " mem"}, mem_word(vq[i].chk_addr), vq[i].chk_word);
      end

      // Reset during the RD cycle of an SB aborts it without a write.
      n_vec++;
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b000;
      req_addr = 32'h41; req_wdata = 32'h12;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      chk("abort in_rd", {31'd0, MemRead}, 32'd1);
      rst = 1'b0;
      #1;
      for (int c = 0; c < 3; c++) begin
         chk("abort req_ready", {31'd0, req_ready}, 32'd1);
         chk("abort resp_valid", {31'd0, resp_valid}, 32'd0);
         chk("abort resp_err", {31'd0, resp_err}, 32'd0);
         chk("abort resp_rdata", resp_rdata, 32'd0);
         chk("abort MemRead", {31'd0, MemRead}, 32'd0);
         chk("abort MemWrite", {31'd0, MemWrite}, 32'd0);
         chk("abort byte_address", byte_address, 32'd0);
         chk("abort write_data", write_data, 32'd0);
         @(negedge clk);
      end
      rst = 1'b1;
      @(negedge clk);
      chk("abort MemWrite_after", {31'd0, MemWrite}, 32'd0);
      chk("abort mem", mem_word(32'h40), 32'hCAFEF00D);

      // Handshake: request held valid continuously, five in a row.
      n_vec++;
      acc = 0; got = 0; just_acc = 1'b0;
      for (int c = 0; c < 80 && got < 5; c++) begin
         @(negedge clk);
         if (just_acc) chk("hs ready_low", {31'd0, req_ready}, 32'd0);
         if (resp_valid) begin
            if (got < acc) begin
               chk($sformatf("hs%0d rdata", got), resp_rdata, hs[got].exp_rdata);
               chk($sformatf("hs%0d err", got), {31'd0, resp_err}, {31'd0, hs[got].exp_err});
            end else begin
               n_bad++;
               $display("FAIL hs unexpected response: got %0d responses with %0d accepts", got + 1, acc);
            end
            got++;
         end
         if (acc < 5) begin
            req_valid  = 1'b1;
            req_write  = hs[acc].wr;
            req_funct3 = hs[acc].f3;
            req_addr   = hs[acc].addr;
            req_wdata  = hs[acc].wdata;
         end else begin
            req_valid = 1'b0;
         end
         was_ready = req_ready;
         @(posedge clk);
         just_acc = was_ready && req_valid;
         if (just_acc) acc++;
      end
      req_valid = 1'b0;
      chk("hs accepts", acc, 5);
      chk("hs responses", got, 5);
      chk("hs mem", mem_word(32'h50), 32'h01020377);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
